// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, PC source
// select codes and the bit index of each pipeline register in stall/flush.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DIV   = 2'd1,
        MWAIT = 2'd2,
        EXC   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEQ     = 2'd0,
        EXC_VEC = 2'd1,
        EPC     = 2'd2
    } pc_sel_e;

    localparam int IF_ID  = 0;
    localparam int ID_EX  = 1;
    localparam int EX_MEM = 2;
    localparam int MEM_WB = 3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, SRAM waits,
// multi-cycle divide and exception/ERET redirect, plus a stall-cycle counter.
//
// state | meaning
// RUN   | normal issue; load-use and fetch-wait bubbles resolved here
// DIV   | divider busy, front of the pipe held, bubbles fed into EX_MEM
// MWAIT | data SRAM wait, whole pipe frozen, bubbles fed into MEM_WB
// EXC   | post-redirect hold, fetch bubbles only, exc/eret ignored
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int EXC_HOLD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lu_hazard_i,
    input  logic             imem_ready_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             ex_div_i,
    input  logic             div_done_i,
    input  logic             exc_i,
    input  logic             eret_i,
    output logic             pc_stall_o,
    output logic [2:0]       stall_o,
    output logic [3:0]       flush_o,
    output logic [1:0]       pc_sel_o,
    output logic             div_start_o,
    output logic             div_abort_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam logic [1:0] HOLD_INIT = 2'(EXC_HOLD - 1);

    state_e     state, state_nxt;
    logic [1:0] hold, hold_nxt;
    logic       redirect, dmem_wait;

    always_comb begin
        pc_stall_o  = 1'b0;
        stall_o     = 3'b000;
        flush_o     = 4'b0000;
        pc_sel_o    = SEQ;
        div_start_o = 1'b0;
        div_abort_o = 1'b0;
        state_nxt   = state;
        hold_nxt    = hold;
        redirect    = (exc_i | eret_i) && (state != EXC);
        dmem_wait   = dmem_req_i & ~dmem_ready_i;

        if (state == EXC) begin
            flush_o[IF_ID] = 1'b1;
            if (hold == 2'd0) begin
                state_nxt = RUN;
            end else begin
                hold_nxt = hold - 2'd1;
            end
        end else if (redirect) begin
            flush_o     = 4'b1111;
            pc_sel_o    = exc_i ? EXC_VEC : EPC;
            div_abort_o = (state == DIV);
            state_nxt   = EXC;
            hold_nxt    = HOLD_INIT;
        end else if (dmem_wait) begin
            pc_stall_o      = 1'b1;
            stall_o         = 3'b111;
            flush_o[MEM_WB] = 1'b1;
            state_nxt       = MWAIT;
        end else if ((state == DIV) && !div_done_i) begin
            pc_stall_o      = 1'b1;
            stall_o         = 3'b011;
            flush_o[EX_MEM] = 1'b1;
        end else if ((state != DIV) && ex_div_i && !div_done_i) begin
            div_start_o     = 1'b1;
            pc_stall_o      = 1'b1;
            stall_o         = 3'b011;
            flush_o[EX_MEM] = 1'b1;
            state_nxt       = DIV;
        end else begin
            // Plain RUN decision; also covers a divide that finishes in its launch cycle.
            div_start_o = (state != DIV) && ex_div_i;
            state_nxt   = RUN;
            if (lu_hazard_i) begin
                pc_stall_o     = 1'b1;
                stall_o[IF_ID] = 1'b1;
                flush_o[ID_EX] = 1'b1;
            end else if (!imem_ready_i) begin
                pc_stall_o     = 1'b1;
                flush_o[IF_ID] = 1'b1;
            end
        end

        // Controls are forced quiet for as long as reset is held.
        if (!rst_n) begin
            pc_stall_o  = 1'b0;
            stall_o     = 3'b000;
            flush_o     = 4'b0000;
            pc_sel_o    = SEQ;
            div_start_o = 1'b0;
            div_abort_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            hold  <= 2'd0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    assign state_o = state;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_stall_o),
        .count (stall_cycles_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl with a few hand-written
// reset sequences; a narrow-counter instance exercises saturation.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lu_hazard, imem_ready, dmem_req, dmem_ready;
    logic        ex_div, div_done, exc, eret;
    logic        pc_stall;
    logic [2:0]  stall;
    logic [3:0]  flush;
    logic [1:0]  pc_sel;
    logic        div_start, div_abort;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    logic        s_pc_stall;
    logic [2:0]  s_stall;
    logic [3:0]  s_flush;
    logic [1:0]  s_pc_sel;
    logic        s_div_start, s_div_abort;
    logic [1:0]  s_state;
    logic [2:0]  s_stall_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(32), .EXC_HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .lu_hazard_i(lu_hazard), .imem_ready_i(imem_ready),
        .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
        .ex_div_i(ex_div), .div_done_i(div_done),
        .exc_i(exc), .eret_i(eret),
        .pc_stall_o(pc_stall), .stall_o(stall), .flush_o(flush),
        .pc_sel_o(pc_sel), .div_start_o(div_start), .div_abort_o(div_abort),
        .state_o(state), .stall_cycles_o(stall_cycles)
    );

    pipe_hazard_ctrl #(.CNT_W(3), .EXC_HOLD(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .lu_hazard_i(lu_hazard), .imem_ready_i(imem_ready),
        .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
        .ex_div_i(ex_div), .div_done_i(div_done),
        .exc_i(exc), .eret_i(eret),
        .pc_stall_o(s_pc_stall), .stall_o(s_stall), .flush_o(s_flush),
        .pc_sel_o(s_pc_sel), .div_start_o(s_div_start), .div_abort_o(s_div_abort),
        .state_o(s_state), .stall_cycles_o(s_stall_cycles)
    );

    typedef struct {
        logic [7:0] in;      // {lu, imem_ready, dmem_req, dmem_ready, ex_div, div_done, exc, eret}
        logic [1:0] st;
        logic       pcs;
        logic [2:0] stl;
        logic [3:0] fl;
        logic [1:0] sel;
        logic       start;
        logic       abort;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [7:0] in, logic [1:0] st, logic pcs, logic [2:0] stl,
                                logic [3:0] fl, logic [1:0] sel, logic start, logic abort);
        vec_t v;
        v.in = in; v.st = st; v.pcs = pcs; v.stl = stl;
        v.fl = fl; v.sel = sel; v.start = start; v.abort = abort;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [7:0] in);
        lu_hazard  = in[7];
        imem_ready = in[6];
        dmem_req   = in[5];
        dmem_ready = in[4];
        ex_div     = in[3];
        div_done   = in[2];
        exc        = in[1];
        eret       = in[0];
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, " pc_stall"},  32'(pc_stall),  32'd0);
        chk({tag, " stall"},     32'(stall),     32'd0);
        chk({tag, " flush"},     32'(flush),     32'd0);
        chk({tag, " pc_sel"},    32'(pc_sel),    32'd0);
        chk({tag, " div_start"}, 32'(div_start), 32'd0);
        chk({tag, " div_abort"}, 32'(div_abort), 32'd0);
        chk({tag, " state"},     32'(state),     32'd0);
        chk({tag, " cnt"},       stall_cycles,   32'd0);
    endtask

    localparam logic [7:0] IDL = 8'b0100_0000;

    initial begin
        // RUN basics
        vq.push_back(mk(IDL,          2'd0, 1'b0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b1100_0000, 2'd0, 1'b1, 3'b001, 4'b0010, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0000_0000, 2'd0, 1'b1, 3'b000, 4'b0001, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b1000_0000, 2'd0, 1'b1, 3'b001, 4'b0010, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd0, 1'b0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // divide, done four cycles after launch
        vq.push_back(mk(8'b0100_1000, 2'd0, 1'b1, 3'b011, 4'b0100, 2'd0, 1'b1, 1'b0));
        vq.push_back(mk(8'b0100_1000, 2'd1, 1'b1, 3'b011, 4'b0100, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0100_1000, 2'd1, 1'b1, 3'b011, 4'b0100, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0100_1000, 2'd1, 1'b1, 3'b011, 4'b0100, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0100_1100, 2'd1, 1'b0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd0, 1'b0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // data SRAM wait arriving during divide
        vq.push_back(mk(8'b0100_1000, 2'd0, 1'b1, 3'b011, 4'b0100, 2'd0, 1'b1, 1'b0));
        vq.push_back(mk(8'b0110_1000, 2'd1, 1'b1, 3'b111, 4'b1000, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0110_1000, 2'd2, 1'b1, 3'b111, 4'b1000, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0110_1000, 2'd2, 1'b1, 3'b111, 4'b1000, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0111_0000, 2'd2, 1'b0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd0, 1'b0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // exception in second divide cycle, exc held through EXC
        vq.push_back(mk(8'b0100_1000, 2'd0, 1'b1, 3'b011, 4'b0100, 2'd0, 1'b1, 1'b0));
        vq.push_back(mk(8'b0100_1010, 2'd1, 1'b0, 3'b000, 4'b1111, 2'd1, 1'b0, 1'b1));
        vq.push_back(mk(8'b0100_0010, 2'd3, 1'b0, 3'b000, 4'b0001, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0100_0010, 2'd3, 1'b0, 3'b000, 4'b0001, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd0, 1'b0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // exc and eret together, then eret alone
        vq.push_back(mk(8'b0100_0011, 2'd0, 1'b0, 3'b000, 4'b1111, 2'd1, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd3, 1'b0, 3'b000, 4'b0001, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd3, 1'b0, 3'b000, 4'b0001, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0100_0001, 2'd0, 1'b0, 3'b000, 4'b1111, 2'd2, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd3, 1'b0, 3'b000, 4'b0001, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd3, 1'b0, 3'b000, 4'b0001, 2'd0, 1'b0, 1'b0));
        // wait from RUN, redirect out of MWAIT (no abort), wait ignored in EXC
        vq.push_back(mk(8'b0110_0000, 2'd0, 1'b1, 3'b111, 4'b1000, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(8'b0110_0010, 2'd2, 1'b0, 3'b000, 4'b1111, 2'd1, 1'b0, 1'b0));
        vq.push_back(mk(8'b0110_0000, 2'd3, 1'b0, 3'b000, 4'b0001, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd3, 1'b0, 3'b000, 4'b0001, 2'd0, 1'b0, 1'b0));
        vq.push_back(mk(IDL,          2'd0, 1'b0, 3'b000, 4'b0000, 2'd0, 1'b0, 1'b0));

        // reset: outputs quiet even with a hazard present
        rst_n = 1'b0;
        drive(8'b1000_0000);
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        drive(IDL);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            string t;
            t = $sformatf("v%0d", i);
            drive(vq[i].in);
            #3;
            chk({t, " state"},     32'(state),     32'(vq[i].st));
            chk({t, " pc_stall"},  32'(pc_stall),  32'(vq[i].pcs));
            chk({t, " stall"},     32'(stall),     32'(vq[i].stl));
            chk({t, " flush"},     32'(flush),     32'(vq[i].fl));
            chk({t, " pc_sel"},    32'(pc_sel),    32'(vq[i].sel));
            chk({t, " div_start"}, 32'(div_start), 32'(vq[i].start));
            chk({t, " div_abort"}, 32'(div_abort), 32'(vq[i].abort));
            if (i == 1) chk("cnt after load-use", stall_cycles, 32'd0);
            if (i == 2) chk("cnt after first stall", stall_cycles, 32'd1);
            @(posedge clk);
            #1;
        end
        // stall cycles: 3 RUN + 4 DIV + 4 DIV/MWAIT + 1 DIV + 1 MWAIT
        chk("cnt total", stall_cycles, 32'd13);
        chk("sat cnt", 32'(s_stall_cycles), 32'd7);

        // reset asserted mid-MWAIT
        drive(8'b1110_0000);
        @(posedge clk);
        #1;
        chk("mwait entered", 32'(state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("rst mwait");
        chk("rst mwait sat cnt", 32'(s_stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        drive(IDL);
        rst_n = 1'b1;

        // reset asserted mid-DIV: no abort pulse
        drive(8'b0100_1000);
        @(posedge clk);
        #1;
        chk("div entered", 32'(state), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("rst div");
        @(posedge clk);
        #1;
        drive(IDL);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
